// File: rtl/atm_pkg.sv
// Shared definitions for the ATM transaction controller.
//   BAL_W / NUM_ACCTS / ACCT_W : datapath and account-file geometry
//   OP_*                       : Select opcodes
//   ERR_*                      : completion status codes reported on err
//   state_t                    : controller FSM states
package atm_pkg;

  localparam int NUM_ACCTS = 16;
  localparam int ACCT_W    = 4;
  localparam int BAL_W     = 10;

  // Select opcodes
  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_XFR = 2'b11;

  // Completion status codes
  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NSF  = 2'b01;  // insufficient funds
  localparam logic [1:0] ERR_OVF  = 2'b10;  // balance would exceed 1023
  localparam logic [1:0] ERR_SAME = 2'b11;  // transfer to the source account

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC_S = 3'd1,
    CALC_D = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/atm_addsub.sv
// Single shared add/subtract unit of the ATM datapath.
//   a, b   : BAL_W-bit unsigned operands
//   sub    : 0 -> a + b, 1 -> a - b
//   result : BAL_W+1 bits; the MSB is the carry (add) or borrow (sub)
module atm_addsub
  import atm_pkg::*;
(
  input  logic [BAL_W-1:0] a,
  input  logic [BAL_W-1:0] b,
  input  logic             sub,
  output logic [BAL_W:0]   result
);

  // Zero-extending both operands makes bit BAL_W the carry for an add and
  // the borrow (a < b) for a subtract.
  always_comb begin
    if (sub) begin
      result = {1'b0, a} - {1'b0, b};
    end else begin
      result = {1'b0, a} + {1'b0, b};
    end
  end

endmodule

// File: rtl/atm_txn_controller.sv
// ATM transaction controller: owns a 16 x 10-bit balance file and runs
// inquiry / deposit / withdraw / transfer through one shared add/sub unit.
// Every transaction is fully checked before any balance is written, and all
// writes of a transaction happen in the single COMMIT cycle.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : transaction request, sampled only in IDLE
//   Select            : 00 inquiry, 01 deposit, 10 withdraw, 11 transfer
//   AccountNumber_s   : source account
//   AccountNumber_d   : destination account (transfer only)
//   Amount            : transaction amount (ignored for inquiry)
//   busy              : high from acceptance through the done cycle
//   done              : one-cycle completion pulse
//   err               : completion status, held until the next done
//   Balance           : source balance after the transaction, held until next done
//   txn_count         : (ATM_TXN_COUNT_EN only) count of successful non-inquiry txns
//   dbg_state         : current FSM state, for observation
//
// Build option: define ATM_TXN_COUNT_EN to add the txn_count output.
//
// Handshake: a request is accepted on a rising edge where the FSM is in IDLE
// and start=1; the inputs are captured on that edge and never re-sampled.
// done is high for exactly one cycle, during which the FSM is already back in
// IDLE, so a start held high is accepted on the edge that ends the done cycle.
// start while a transaction is in flight is dropped, not queued.
module atm_txn_controller
  import atm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        Select,
  input  logic [ACCT_W-1:0] AccountNumber_s,
  input  logic [ACCT_W-1:0] AccountNumber_d,
  input  logic [BAL_W-1:0]  Amount,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [BAL_W-1:0]  Balance,
`ifdef ATM_TXN_COUNT_EN
  output logic [15:0]       txn_count,
`endif
  output state_t            dbg_state
);

  state_t state, state_next;

  // Captured transaction
  logic [1:0]        sel_r;
  logic [ACCT_W-1:0] s_r;
  logic [ACCT_W-1:0] d_r;
  logic [BAL_W-1:0]  amt_r;

  // Pre-computed results awaiting COMMIT
  logic [BAL_W-1:0]  new_s;
  logic [BAL_W-1:0]  new_d;
  logic [1:0]        err_r;
  logic [1:0]        err_next;

  logic [BAL_W-1:0]  bal [NUM_ACCTS];

  logic              accept;
  logic              load_s;
  logic              load_d;
  logic              commit;
  logic [BAL_W-1:0]  add_a;
  logic              add_sub;
  logic [BAL_W:0]    add_res;

  assign accept    = (state == IDLE) && start;
  assign dbg_state = state;

  atm_addsub u_addsub (
    .a      (add_a),
    .b      (amt_r),
    .sub    (add_sub),
    .result (add_res)
  );

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    err_next   = err_r;
    load_s     = 1'b0;
    load_d     = 1'b0;
    commit     = 1'b0;
    add_a      = bal[s_r];
    add_sub    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          err_next   = ERR_OK;
          state_next = (Select == OP_INQ) ? DONE : CALC_S;
        end
      end

      CALC_S: begin
        add_a   = bal[s_r];
        add_sub = (sel_r != OP_DEP);
        if (add_res[BAL_W]) begin
          err_next   = (sel_r == OP_DEP) ? ERR_OVF : ERR_NSF;
          state_next = DONE;
        end else begin
          load_s     = 1'b1;
          state_next = (sel_r == OP_XFR) ? CALC_D : COMMIT;
        end
      end

      CALC_D: begin
        add_a   = bal[d_r];
        add_sub = 1'b0;
        if (s_r == d_r) begin
          err_next   = ERR_SAME;
          state_next = DONE;
        end else if (add_res[BAL_W]) begin
          err_next   = ERR_OVF;
          state_next = DONE;
        end else begin
          load_d     = 1'b1;
          state_next = COMMIT;
        end
      end

      COMMIT: begin
        commit     = 1'b1;
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction capture, intermediate results and outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r   <= OP_INQ;
      s_r     <= '0;
      d_r     <= '0;
      amt_r   <= '0;
      new_s   <= '0;
      new_d   <= '0;
      err_r   <= ERR_OK;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= ERR_OK;
      Balance <= '0;
    end else begin
      if (accept) begin
        sel_r <= Select;
        s_r   <= AccountNumber_s;
        d_r   <= AccountNumber_d;
        amt_r <= Amount;
      end
      if (load_s) begin
        new_s <= add_res[BAL_W-1:0];
      end
      if (load_d) begin
        new_d <= add_res[BAL_W-1:0];
      end
      err_r <= err_next;
      // Outputs are registered off the DONE state, so the done cycle itself is
      // spent in IDLE; busy stays high through it (and beyond, if a held start
      // is accepted at its end).
      busy  <= (state_next != IDLE) || (state == DONE);
      done  <= (state == DONE);
      if (state == DONE) begin
        err     <= err_r;
        Balance <= bal[s_r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Balance file. Both halves of a transfer land on the same edge, so a reset
  // can never leave one account debited without the other credited.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        bal[i] <= '0;
      end
    end else if (commit) begin
      bal[s_r] <= new_s;
      if (sel_r == OP_XFR) begin
        bal[d_r] <= new_d;
      end
    end
  end

`ifdef ATM_TXN_COUNT_EN
  // Successful balance-changing transactions; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if ((state == DONE) && (err_r == ERR_OK) && (sel_r != OP_INQ)) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_atm_txn_controller.sv
// Bench for atm_txn_controller: directed scenarios plus random transactions,
// checked against an account-level model of the ATM rules.
module tb_atm_txn_controller;
  import atm_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [3:0]  acct_s = 4'd0;
  logic [3:0]  acct_d = 4'd0;
  logic [9:0]  amount = 10'd0;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [9:0]  balance;
  state_t      dbg_state;
`ifdef ATM_TXN_COUNT_EN
  logic [15:0] txn_count;
`endif

  always #5 clk = ~clk;

  atm_txn_controller dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .Select          (sel),
    .AccountNumber_s (acct_s),
    .AccountNumber_d (acct_d),
    .Amount          (amount),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .Balance         (balance),
`ifdef ATM_TXN_COUNT_EN
    .txn_count       (txn_count),
`endif
    .dbg_state       (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  typedef struct {
    int err;
    int bal;
    int lat;
    int acc;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   bal_m [16];
  int   exp_cnt = 0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   last_err = 0;
  int   last_bal = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Account-level model: applies one transaction to bal_m and returns the
  // status, reported balance and acceptance-to-done latency it must produce.
  task automatic model(input int op, input int s, input int d, input int amt,
                       output exp_t e);
    e.err = 0;
    e.lat = 1;
    case (op)
      0: e.lat = 1;
      1: begin
        if (bal_m[s] + amt > 1023) begin e.err = 2; e.lat = 2; end
        else begin bal_m[s] += amt; e.lat = 3; end
      end
      2: begin
        if (amt > bal_m[s]) begin e.err = 1; e.lat = 2; end
        else begin bal_m[s] -= amt; e.lat = 3; end
      end
      default: begin
        if (amt > bal_m[s])             begin e.err = 1; e.lat = 2; end
        else if (s == d)                begin e.err = 3; e.lat = 3; end
        else if (bal_m[d] + amt > 1023) begin e.err = 2; e.lat = 3; end
        else begin
          bal_m[s] -= amt;
          bal_m[d] += amt;
          e.lat = 4;
        end
      end
    endcase
    if (e.err == 0 && op != 0) exp_cnt = (exp_cnt + 1) % 65536;
    e.bal = bal_m[s];
    e.cnt = exp_cnt;
  endtask

  // ---------------------------------------------------------------------------
  // Compare process: every cycle out of reset
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("busy", int'(busy), int'(exp_q.size() > 0));
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("err", int'(err), e.err);
          check("balance", int'(balance), e.bal);
          check("latency", cyc - e.acc, e.lat);
`ifdef ATM_TXN_COUNT_EN
          check("txn_count", int'(txn_count), e.cnt);
`endif
        end
        last_err = int'(err);
        last_bal = int'(balance);
        n_done++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Called while the DUT is in IDLE; returns #1 after the acceptance edge.
  task automatic issue_txn(input int op, input int s, input int d, input int amt,
                           input bit hold);
    exp_t e;
    sel    = 2'(op);
    acct_s = 4'(s);
    acct_d = 4'(d);
    amount = 10'(amt);
    start  = 1'b1;
    @(posedge clk);
    #1;
    model(op, s, d, amt, e);
    e.acc = cyc;
    exp_q.push_back(e);
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done();
    int n0 = n_done;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (n_done != n0) break;
    end
    check("done_timeout", int'(n_done != n0), 1);
  endtask

  task automatic txn(input int op, input int s, input int d, input int amt);
    issue_txn(op, s, d, amt, 1'b0);
    wait_done();
  endtask

  // Directed transaction with hand-computed status and balance.
  task automatic txn_lit(input string name, input int op, input int s, input int d,
                         input int amt, input int lit_err, input int lit_bal);
    txn(op, s, d, amt);
    check({name, "_err"}, last_err, lit_err);
    check({name, "_bal"}, last_bal, lit_bal);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 16; i++) bal_m[i] = 0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n0;
    apply_reset();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_balance", int'(balance), 0);
    check("rst_state", int'(dbg_state), int'(IDLE));
    @(negedge clk);
    #1;

    txn_lit("dep200", 1, 4, 0, 200, 0, 200);
    txn_lit("dep100", 1, 2, 0, 100, 0, 100);
    txn_lit("xfr50", 3, 4, 2, 50, 0, 150);
    txn_lit("inq2", 0, 2, 0, 0, 0, 150);
    txn_lit("wdr300", 2, 4, 0, 300, 1, 150);
    txn_lit("inq4", 0, 4, 0, 0, 0, 150);
    txn_lit("dep1000", 1, 2, 0, 1000, 2, 150);
    txn_lit("inq2b", 0, 2, 0, 0, 0, 150);
    txn_lit("xfr_same", 3, 4, 4, 10, 3, 150);
    txn_lit("dep0", 1, 4, 0, 0, 0, 150);
    txn_lit("wdr_all", 2, 4, 0, 150, 0, 0);
    txn_lit("dep_max", 1, 9, 0, 1023, 0, 1023);
    txn_lit("dep_ovf1", 1, 9, 0, 1, 2, 1023);
    txn_lit("refill4", 1, 4, 0, 150, 0, 150);

    // Reset while the transfer sits in CALC_D: nothing may be committed.
    issue_txn(3, 4, 2, 20, 1'b0);
    @(posedge clk);
    #1;
    check("state_calc_d", int'(dbg_state), int'(CALC_D));
    rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_balance", int'(balance), 0);
    check("midrst_state", int'(dbg_state), int'(IDLE));
    apply_reset();
    @(negedge clk);
    #1;
    for (int a = 0; a < 16; a++) txn_lit("inq_after_rst", 0, a, 0, 0, 0, 0);

    // start held high: one transaction, the next accepted only after done.
    issue_txn(1, 7, 0, 5, 1'b1);
    wait_done();
    check("hold_first_bal", last_bal, 5);
    @(posedge clk);
    #1;
    begin
      exp_t e;
      model(1, 7, 0, 5, e);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    start = 1'b0;
    wait_done();
    check("hold_second_bal", last_bal, 10);
    n0 = n_done;
    repeat (6) @(negedge clk);
    #1;
    check("hold_no_extra", n_done - n0, 0);

    // Random transactions
    for (int k = 0; k < 250; k++) begin
      int op, s, d, amt;
      op  = $urandom_range(0, 3);
      s   = $urandom_range(0, 15);
      d   = ($urandom_range(0, 7) == 0) ? s : $urandom_range(0, 15);
      amt = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 120);
      txn(op, s, d, amt);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
        #1;
      end
    end

    // Final sweep: every account balance must match the model.
    for (int a = 0; a < 16; a++) begin
      txn(0, a, 0, 0);
      check("final_bal", last_bal, bal_m[a]);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
